// File: rtl/ifetch_pkg.sv
// Shared types and defaults for the instruction-fetch prefetch stage.
package ifetch_pkg;

    localparam int unsigned DEF_ADDR_W = 16;
    localparam int unsigned DEF_DATA_W = 16;

    typedef enum logic [0:0] {
        FETCH = 1'b0,
        DRAIN = 1'b1
    } state_e;

    typedef struct packed {
        logic [DEF_ADDR_W-1:0] pc;
        logic [DEF_DATA_W-1:0] instr;
    } entry_t;

endpackage

// File: rtl/ifetch_queue.sv
// Prefetch FIFO: DEPTH entries, flush beats push/pop, head read from the storage registers.
module ifetch_queue
    import ifetch_pkg::*;
#(
    parameter int unsigned WIDTH = $bits(entry_t),
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         push_data,
    output logic [WIDTH-1:0]         head,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            // Push on a full queue is only legal with a pop in the same cycle.
            if (push) begin
                mem_q[wr_ptr_q] <= push_data;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            unique case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/ifetch_prefetch.sv
// Instruction fetch with prefetch queue, credit-limited requests and redirect draining.
// Optional IFETCH_PERF_EN adds saturating delivered/flushed counters.
module ifetch_prefetch
    import ifetch_pkg::*;
#(
    parameter int unsigned        ADDR_W   = DEF_ADDR_W,
    parameter int unsigned        DATA_W   = DEF_DATA_W,
    parameter int unsigned        DEPTH    = 4,
    parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [ADDR_W-1:0] imem_req_addr,
    input  logic              imem_rsp_valid,
    input  logic [DATA_W-1:0] imem_rsp_data,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_instr,
    output logic [ADDR_W-1:0] out_pc
`ifdef IFETCH_PERF_EN
    ,
    output logic [31:0]       perf_fetched,
    output logic [31:0]       perf_flushed
`endif
);

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
    localparam int unsigned SUM_W = CNT_W + 1;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   fetch_pc_q, fetch_pc_d;
    logic [ADDR_W-1:0]   rsp_pc_q, rsp_pc_d;
    logic [ADDR_W-1:0]   req_addr_q, req_addr_d;
    logic                req_valid_q, req_valid_d;
    logic [CNT_W-1:0]    outstanding_q, outstanding_d;
    logic [CNT_W-1:0]    stale_q, stale_d;
    logic [CNT_W-1:0]    q_count, q_count_d;
    logic [SUM_W-1:0]    inflight_d;
    logic [ADDR_W+DATA_W-1:0] head;
    logic                req_fire, out_fire, held, drop, push, pop;

    assign req_fire = req_valid_q & imem_req_ready;
    assign held     = req_valid_q & ~imem_req_ready;
    assign out_fire = out_valid & out_ready;
    assign drop     = redirect_valid | (state_q == DRAIN);
    assign push     = imem_rsp_valid & ~drop;
    assign pop      = out_fire & ~redirect_valid;

    ifetch_queue #(
        .WIDTH (ADDR_W + DATA_W),
        .DEPTH (DEPTH)
    ) u_queue (
        .clk       (clk),
        .reset     (reset),
        .flush     (redirect_valid),
        .push      (push),
        .pop       (pop),
        .push_data ({rsp_pc_q, imem_rsp_data}),
        .head      (head),
        .count     (q_count)
    );

    always_comb begin
        outstanding_d = outstanding_q;
        if (req_fire && !imem_rsp_valid) begin
            outstanding_d = outstanding_q + 1'b1;
        end else if (!req_fire && imem_rsp_valid) begin
            outstanding_d = outstanding_q - 1'b1;
        end

        q_count_d = q_count;
        if (redirect_valid) begin
            q_count_d = '0;
        end else if (push && !pop) begin
            q_count_d = q_count + 1'b1;
        end else if (!push && pop) begin
            q_count_d = q_count - 1'b1;
        end

        fetch_pc_d = fetch_pc_q;
        rsp_pc_d   = rsp_pc_q;
        stale_d    = stale_q;
        if (req_fire) begin
            fetch_pc_d = fetch_pc_q + 1'b1;
        end
        if (push) begin
            rsp_pc_d = rsp_pc_q + 1'b1;
        end
        if (state_q == DRAIN && imem_rsp_valid && stale_q != '0) begin
            stale_d = stale_q - 1'b1;
        end
        // Everything in flight is stale, including a held request that has not fired yet.
        if (redirect_valid) begin
            fetch_pc_d = redirect_pc;
            rsp_pc_d   = redirect_pc;
            stale_d    = outstanding_d + CNT_W'(held);
        end

        state_d = state_q;
        unique case (state_q)
            FETCH:   if (redirect_valid && stale_d != '0) state_d = DRAIN;
            DRAIN:   if (stale_d == '0) state_d = FETCH;
            default: state_d = FETCH;
        endcase

        // Credit is evaluated on next-cycle values so req_valid can be a plain register.
        inflight_d  = SUM_W'(outstanding_d) + SUM_W'(q_count_d);
        req_valid_d = held | ((state_d == FETCH) && (inflight_d < SUM_W'(DEPTH)));
        req_addr_d  = held ? req_addr_q : fetch_pc_d;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= FETCH;
            fetch_pc_q    <= RESET_PC;
            rsp_pc_q      <= RESET_PC;
            req_addr_q    <= RESET_PC;
            req_valid_q   <= 1'b0;
            outstanding_q <= '0;
            stale_q       <= '0;
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            rsp_pc_q      <= rsp_pc_d;
            req_addr_q    <= req_addr_d;
            req_valid_q   <= req_valid_d;
            outstanding_q <= outstanding_d;
            stale_q       <= stale_d;
        end
    end

    assign imem_req_valid      = req_valid_q;
    assign imem_req_addr       = req_addr_q;
    assign out_valid           = (q_count != '0);
    assign {out_pc, out_instr} = head;

`ifdef IFETCH_PERF_EN
    logic [31:0]      perf_fetched_q, perf_flushed_q;
    logic [SUM_W-1:0] flush_inc;
    logic [32:0]      flushed_sum;

    // Flushed work = queued entries thrown away on redirect + every dropped response.
    assign flush_inc   = (redirect_valid ? SUM_W'(q_count) : '0) + SUM_W'(imem_rsp_valid & drop);
    assign flushed_sum = {1'b0, perf_flushed_q} + 33'(flush_inc);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_fetched_q <= '0;
            perf_flushed_q <= '0;
        end else begin
            if (pop && !(&perf_fetched_q)) begin
                perf_fetched_q <= perf_fetched_q + 1'b1;
            end
            perf_flushed_q <= flushed_sum[32] ? '1 : flushed_sum[31:0];
        end
    end

    assign perf_fetched = perf_fetched_q;
    assign perf_flushed = perf_flushed_q;
`endif

endmodule
